// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU: opcodes, FSM state encoding and PSW bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] OP_ADD  = 32'h00;
  localparam logic [31:0] OP_ADDC = 32'h01;
  localparam logic [31:0] OP_INC  = 32'h02;
  localparam logic [31:0] OP_DEC  = 32'h03;
  localparam logic [31:0] OP_SUBB = 32'h04;
  localparam logic [31:0] OP_MUL  = 32'h05;
  localparam logic [31:0] OP_DIV  = 32'h06;
  localparam logic [31:0] OP_DA   = 32'h07;
  localparam logic [31:0] OP_ANL  = 32'h08;
  localparam logic [31:0] OP_ORL  = 32'h09;
  localparam logic [31:0] OP_XRL  = 32'h0A;
  localparam logic [31:0] OP_SETB = 32'h0B;
  localparam logic [31:0] OP_CLR  = 32'h0C;
  localparam logic [31:0] OP_CPL  = 32'h0D;
  localparam logic [31:0] OP_RL   = 32'h0E;
  localparam logic [31:0] OP_RLC  = 32'h0F;
  localparam logic [31:0] OP_RR   = 32'h10;
  localparam logic [31:0] OP_RRC  = 32'h11;
  localparam logic [31:0] OP_SWAP = 32'h12;

  localparam int PSW_CY = 7;
  localparam int PSW_AC = 6;
  localparam int PSW_OV = 2;
  localparam int PSW_P  = 0;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply / restoring divide, one step per cycle, WIDTH steps.
// The first step is applied on the start edge so the final step lands WIDTH-1 cycles later.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             div_q;
  logic [WIDTH-1:0] opnd_q;

  logic [WIDTH-1:0] src_hi, src_lo, src_d, addend, nxt_hi, nxt_lo;
  logic             src_div;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  // hi/lo hold {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    src_hi    = start ? '0 : hi;
    src_lo    = start ? a_data : lo;
    src_d     = start ? b_data : opnd_q;
    src_div   = start ? is_div : div_q;
    addend    = src_lo[0] ? src_d : '0;
    mul_sum   = {1'b0, src_hi} + {1'b0, addend};
    div_shift = {src_hi, src_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, src_d};
    if (src_div) begin
      if (!div_diff[WIDTH]) begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {src_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {src_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], src_lo[WIDTH-1:1]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        hi     <= nxt_hi;
        lo     <= nxt_lo;
        opnd_q <= b_data;
        div_q  <= is_div;
        cnt_q  <= CNT_W'(WIDTH - 1);
        run_q  <= 1'b1;
      end else if (run_q) begin
        hi    <= nxt_hi;
        lo    <= nxt_lo;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle 8051-style ALU: single-cycle logic/arith ops, iterative MUL/DIV.
// Optional decimal adjust (DA, opcode 0x07) is built only when ALU_MC_DA_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [7:0]       psw_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic [7:0]       psw_out
);

  state_t state_q, state_d;

  logic [31:0]      op_ext;
  logic             is_md, accept;
  logic [WIDTH-1:0] res_ans;
  logic [7:0]       res_psw, md_psw, psw_lat;
  logic             bzero_q, div_q;
  logic [WIDTH:0]   wide;
  logic [4:0]       nib;
  logic             c0;
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
`ifdef ALU_MC_DA_EN
  logic [8:0]       da_v;
  logic             da_cy;
`endif

  assign op_ext = 32'(op);
  assign is_md  = (op_ext == OP_MUL) || (op_ext == OP_DIV);
  assign accept = start && (state_q == ST_IDLE);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_md),
    .is_div (op_ext == OP_DIV),
    .a_data (a_data),
    .b_data (b_data),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = is_md ? ST_ITER : ST_DONE;
      ST_ITER: if (md_done) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    res_ans = '0;
    res_psw = psw_in;
    wide    = '0;
    nib     = '0;
    c0      = 1'b0;
`ifdef ALU_MC_DA_EN
    da_v    = '0;
    da_cy   = 1'b0;
`endif
    case (op_ext)
      OP_ADD, OP_ADDC: begin
        c0   = (op_ext == OP_ADDC) && psw_in[PSW_CY];
        wide = {1'b0, a_data} + {1'b0, b_data} + {{WIDTH{1'b0}}, c0};
        nib  = {1'b0, a_data[3:0]} + {1'b0, b_data[3:0]} + {4'b0, c0};
        res_ans         = wide[WIDTH-1:0];
        res_psw[PSW_CY] = wide[WIDTH];
        res_psw[PSW_AC] = nib[4];
        res_psw[PSW_OV] = (a_data[WIDTH-1] == b_data[WIDTH-1]) && (wide[WIDTH-1] != a_data[WIDTH-1]);
      end
      OP_SUBB: begin
        c0   = psw_in[PSW_CY];
        wide = {1'b0, a_data} - {1'b0, b_data} - {{WIDTH{1'b0}}, c0};
        nib  = {1'b0, a_data[3:0]} - {1'b0, b_data[3:0]} - {4'b0, c0};
        res_ans         = wide[WIDTH-1:0];
        res_psw[PSW_CY] = wide[WIDTH];
        res_psw[PSW_AC] = nib[4];
        res_psw[PSW_OV] = (a_data[WIDTH-1] != b_data[WIDTH-1]) && (wide[WIDTH-1] != a_data[WIDTH-1]);
      end
      OP_INC:  res_ans = a_data + WIDTH'(1);
      OP_DEC:  res_ans = a_data - WIDTH'(1);
`ifdef ALU_MC_DA_EN
      OP_DA: begin
        da_v = {1'b0, 8'(a_data)};
        if (da_v[3:0] > 4'd9 || psw_in[PSW_AC]) da_v = da_v + 9'h006;
        da_cy = psw_in[PSW_CY] | da_v[8];
        if (da_v[7:4] > 4'd9 || da_cy) da_v = {1'b0, da_v[7:0]} + 9'h060;
        else                           da_v = {1'b0, da_v[7:0]};
        da_cy           = da_cy | da_v[8];
        res_ans         = (a_data & ~WIDTH'(8'hFF)) | WIDTH'(da_v[7:0]);
        res_psw[PSW_CY] = da_cy;
      end
`endif
      OP_ANL:  res_ans = a_data & b_data;
      OP_ORL:  res_ans = a_data | b_data;
      OP_XRL:  res_ans = a_data ^ b_data;
      OP_SETB: res_ans = WIDTH'(1);
      OP_CLR:  res_ans = '0;
      OP_CPL:  res_ans = ~a_data;
      OP_RL:   res_ans = {a_data[WIDTH-2:0], a_data[WIDTH-1]};
      OP_RLC: begin
        res_ans         = {a_data[WIDTH-2:0], psw_in[PSW_CY]};
        res_psw[PSW_CY] = a_data[WIDTH-1];
      end
      OP_RR:   res_ans = {a_data[0], a_data[WIDTH-1:1]};
      OP_RRC: begin
        res_ans         = {psw_in[PSW_CY], a_data[WIDTH-1:1]};
        res_psw[PSW_CY] = a_data[0];
      end
      OP_SWAP: res_ans = {a_data[WIDTH/2-1:0], a_data[WIDTH-1:WIDTH/2]};
      default: res_ans = '0;
    endcase
    res_psw[PSW_P] = ^res_ans;
  end

  // MUL/DIV flags are formed at completion from the PSW captured when the op was accepted.
  always_comb begin
    md_psw         = psw_lat;
    md_psw[PSW_CY] = 1'b0;
    md_psw[PSW_OV] = div_q ? bzero_q : (md_hi != '0);
    md_psw[PSW_P]  = ^md_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans     <= '0;
      ans_hi  <= '0;
      psw_out <= '0;
      psw_lat <= '0;
      bzero_q <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      if (accept) begin
        psw_lat <= psw_in;
        bzero_q <= (b_data == '0);
        div_q   <= (op_ext == OP_DIV);
        if (!is_md) begin
          ans     <= res_ans;
          ans_hi  <= '0;
          psw_out <= res_psw;
        end
      end
      if (state_q == ST_ITER && md_done) begin
        ans     <= md_lo;
        ans_hi  <= md_hi;
        psw_out <= md_psw;
      end
    end
  end

endmodule
